// File: rtl/spi_master.sv
// spi_master: single-mode SPI master (CPHA=0, MSB first, configurable CPOL).
// Shifts one DATA_WIDTH word out on mosi per request, samples miso on each
// leading sclk edge, and returns the received word with a one-cycle rx_valid.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SLAVES     = 1,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          CPOL       = 1'b0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            tx_valid,
    output logic                                            tx_ready,
    input  logic [DATA_WIDTH-1:0]                           tx_data,
    input  logic [((SLAVES > 1) ? $clog2(SLAVES) : 1)-1:0]  tx_ss,
    output logic                                            rx_valid,
    output logic [DATA_WIDTH-1:0]                           rx_data,
    output logic                                            busy,
    output logic                                            sclk,
    output logic                                            mosi,
    input  logic                                            miso,
    output logic [SLAVES-1:0]                               ss_n
);

    localparam int unsigned SSW   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGEW = $clog2(2 * DATA_WIDTH + 1);

    // Reject parameter values that cannot produce a meaningful transfer.
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("spi_master: DATA_WIDTH must be >= 1");
    end
    if (SLAVES < 1) begin : g_bad_slaves
        $error("spi_master: SLAVES must be >= 1");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_master: CLK_DIV must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 state_q;
    logic [DIVW-1:0]        div_q;
    logic [EDGEW-1:0]       edge_q;
    logic [DATA_WIDTH-1:0]  tx_sr_q;
    logic [DATA_WIDTH-1:0]  rx_sr_q;
    logic [DATA_WIDTH-1:0]  rx_data_q;
    logic [SLAVES-1:0]      ss_n_q;
    logic                   tx_ready_q;
    logic                   rx_valid_q;
    logic                   busy_q;
    logic                   sclk_q;
    logic                   mosi_q;

    logic                   tick_c;
    logic [EDGEW-1:0]       edge_d;
    logic [DATA_WIDTH-1:0]  tx_shl_c;
    logic [DATA_WIDTH-1:0]  rx_shift_c;
    logic [SLAVES-1:0]      ss_sel_c;

    // Half-period boundary, next sclk edge index, and shift-register next values.
    assign tick_c     = (div_q == DIVW'(CLK_DIV - 1));
    assign edge_d     = edge_q + EDGEW'(1);
    assign tx_shl_c   = tx_sr_q << 1;
    assign rx_shift_c = (rx_sr_q << 1) | DATA_WIDTH'(miso);

    // Decode the requested slave; an out-of-range index selects nobody.
    always_comb begin
        ss_sel_c = '1;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (tx_ss == SSW'(i)) begin
                ss_sel_c[i] = 1'b0;
            end
        end
    end

    // Transfer sequencer: every phase after IDLE lasts a multiple of CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            ss_n_q     <= '1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == S_IDLE || tick_c) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIVW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_sr_q    <= tx_data;
                        rx_sr_q    <= '0;
                        ss_n_q     <= ss_sel_c;
                        mosi_q     <= tx_data[DATA_WIDTH-1];
                        edge_q     <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SETUP;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    // First leading edge coincides with leaving SETUP.
                    if (tick_c) begin
                        sclk_q  <= ~sclk_q;
                        rx_sr_q <= rx_shift_c;
                        edge_q  <= edge_d;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (tick_c) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_d;
                        if (edge_d[0]) begin
                            rx_sr_q <= rx_shift_c;
                        end else if (edge_d == EDGEW'(2 * DATA_WIDTH)) begin
                            state_q <= S_HOLD;
                        end else begin
                            tx_sr_q <= tx_shl_c;
                            mosi_q  <= tx_shl_c[DATA_WIDTH-1];
                        end
                    end
                end
                S_HOLD: begin
                    if (tick_c) begin
                        ss_n_q     <= '1;
                        mosi_q     <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sr_q;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick_c) begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: loopback, slave model,
// back-to-back requests, slave decode, mid-transfer reset, CPOL=1 timing.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Instance A: 8-bit, 3 slaves, CLK_DIV=2, CPOL=0
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_ss = 2'd0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [2:0] ss_n;

    // Instance B: 8-bit, 1 slave, CLK_DIV=4, CPOL=1, looped back
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2;
    logic [7:0] tx_data2 = 8'h00;
    logic [0:0] tx_ss2 = 1'b0;
    logic       rx_valid2;
    logic [7:0] rx_data2;
    logic       busy2;
    logic       sclk2;
    logic       mosi2;
    logic [0:0] ss_n2;

    // Simple CPHA=0 slave model on ss_n[0]
    logic       loop_en = 1'b1;
    logic [7:0] sl_sr = 8'h00;
    logic [7:0] sl_cap = 8'h00;

    int compared = 0;
    int failed   = 0;

    // Per-transfer observations from run1
    int         rxc, rdyc, rises, pulses, ssl;
    logic [7:0] mw, rxw;
    logic [2:0] ss0;
    logic       mosi0, oh_bad;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : sl_sr[7];

    always @(posedge sclk) if (!ss_n[0]) sl_cap = {sl_cap[6:0], mosi};
    always @(negedge sclk) if (!ss_n[0]) sl_sr = sl_sr << 1;

    spi_master #(.DATA_WIDTH(8), .SLAVES(3), .CLK_DIV(2), .CPOL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_ss(tx_ss), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    spi_master #(.DATA_WIDTH(8), .SLAVES(1), .CLK_DIV(4), .CPOL(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data(tx_data2), .tx_ss(tx_ss2), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .busy(busy2), .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .ss_n(ss_n2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer on instance A; cycle m counts edges after acceptance edge E0.
    task automatic run1(input logic [7:0] d, input logic [1:0] ss);
        logic prev;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_ss    = ss;
        @(negedge clk);
        tx_valid = 1'b0;
        ss0 = ss_n; mosi0 = mosi; prev = sclk;
        rxc = -1; rdyc = -1; rises = 0; pulses = 0; ssl = 0; mw = 8'h00; rxw = 8'h00; oh_bad = 1'b0;
        for (int m = 1; m <= 45; m++) begin
            @(negedge clk);
            if (!prev && sclk) begin
                rises++;
                mw = {mw[6:0], mosi};
            end
            prev = sclk;
            if (rx_valid) begin
                pulses++;
                if (rxc < 0) begin rxc = m; rxw = rx_data; end
            end
            if (tx_ready && rdyc < 0) rdyc = m;
            if (ss_n != 3'b111) ssl++;
            if (!$onehot0(~ss_n)) oh_bad = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss_n", ss_n, 3'b111);
        check("rst_sclk_cpol1", sclk2, 1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        // Loopback 0xA5
        loop_en = 1'b1;
        run1(8'hA5, 2'd0);
        check("lb_ss_n_E0", ss0, 3'b110);
        check("lb_mosi_E0", mosi0, 1);
        check("lb_rx_data", rxw, 8'hA5);
        check("lb_rx_valid_cycle", rxc, 34);
        check("lb_tx_ready_cycle", rdyc, 36);
        check("lb_rises", rises, 8);
        check("lb_mosi_seq", mw, 8'hA5);
        check("lb_pulses", pulses, 1);
        check("lb_busy_end", busy, 0);
        check("lb_onehot", oh_bad, 0);

        // Slave model: master sends 0xC3, slave returns 0x3C
        loop_en = 1'b0;
        sl_sr  = 8'h3C;
        sl_cap = 8'h00;
        run1(8'hC3, 2'd0);
        check("sl_capture", sl_cap, 8'hC3);
        check("sl_rx_data", rxw, 8'h3C);
        check("sl_pulses", pulses, 1);
        check("sl_rx_hold", rx_data, 8'h3C);

        // Back-to-back with tx_valid held high
        loop_en = 1'b1;
        begin
            logic [7:0] rxs [2];
            int np, gap;
            bit seen_hi, acc2;
            np = 0; gap = 0; seen_hi = 0; acc2 = 0;
            rxs[0] = 8'h00; rxs[1] = 8'h00;
            tx_valid = 1'b1; tx_data = 8'h11; tx_ss = 2'd0;
            @(negedge clk);
            tx_data = 8'h22;
            for (int m = 1; m <= 90; m++) begin
                @(negedge clk);
                if (rx_valid) begin
                    if (np < 2) rxs[np] = rx_data;
                    np++;
                end
                if (!acc2) begin
                    if (ss_n == 3'b111) begin
                        seen_hi = 1;
                        gap++;
                    end else if (seen_hi) begin
                        acc2 = 1;
                        tx_valid = 1'b0;
                    end
                end
            end
            tx_valid = 1'b0;
            check("b2b_second_accepted", acc2, 1);
            check("b2b_gap_ge_div", (gap >= 2), 1);
            check("b2b_pulses", np, 2);
            check("b2b_rx0", rxs[0], 8'h11);
            check("b2b_rx1", rxs[1], 8'h22);
        end

        // Slave decode: index 2 and out-of-range index 3
        run1(8'h5A, 2'd2);
        check("ss2_ss_n", ss0, 3'b011);
        check("ss2_rx_cycle", rxc, 34);
        check("ss2_rx_data", rxw, 8'h5A);
        check("ss2_onehot", oh_bad, 0);
        run1(8'h96, 2'd3);
        check("ss3_ss_n_E0", ss0, 3'b111);
        check("ss3_never_low", ssl, 0);
        check("ss3_rx_cycle", rxc, 34);
        check("ss3_pulses", pulses, 1);

        // Reset after the third rising sclk edge; request held alongside reset
        begin
            logic prev;
            int r, np;
            tx_valid = 1'b1; tx_data = 8'hF0; tx_ss = 2'd1;
            @(negedge clk);
            tx_valid = 1'b0;
            prev = sclk; r = 0;
            for (int m = 0; m < 40 && r < 3; m++) begin
                @(negedge clk);
                if (!prev && sclk) r++;
                prev = sclk;
            end
            check("mid_reached_3rd_rise", r, 3);
            rst = 1'b1;
            tx_valid = 1'b1;
            @(negedge clk);
            check("mid_ss_n", ss_n, 3'b111);
            check("mid_sclk", sclk, 0);
            check("mid_mosi", mosi, 0);
            check("mid_busy", busy, 0);
            check("mid_tx_ready", tx_ready, 0);
            check("mid_rx_valid", rx_valid, 0);
            check("mid_rx_data", rx_data, 8'h00);
            rst = 1'b0;
            tx_valid = 1'b0;
            @(negedge clk);
            check("mid_ready_after", tx_ready, 1);
            np = 0;
            for (int m = 0; m < 40; m++) begin
                @(negedge clk);
                if (rx_valid) np++;
            end
            check("mid_no_rx_valid", np, 0);
        end

        // CPOL=1, CLK_DIV=4, 0x80 on instance B
        begin
            int tog, rxc2, rdy2;
            logic [7:0] rxw2;
            tog = -1; rxc2 = -1; rdy2 = -1; rxw2 = 8'h00;
            check("cpol1_idle", sclk2, 1);
            tx_valid2 = 1'b1; tx_data2 = 8'h80;
            @(negedge clk);
            tx_valid2 = 1'b0;
            for (int m = 1; m <= 80; m++) begin
                @(negedge clk);
                if (!sclk2 && tog < 0) tog = m;
                if (rx_valid2 && rxc2 < 0) begin rxc2 = m; rxw2 = rx_data2; end
                if (tx_ready2 && rdy2 < 0) rdy2 = m;
            end
            check("cpol1_first_toggle", tog, 4);
            check("cpol1_rx_cycle", rxc2, 68);
            check("cpol1_rx_data", rxw2, 8'h80);
            check("cpol1_ready_cycle", rdy2, 72);
            check("cpol1_idle_end", sclk2, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
